// File: rtl/trace_buffer_pkg.sv
// Shared definitions for the trace buffer.
// Holds the displayed-value kind encoding, the controller state encoding,
// the layout of one trace entry and the default size constants.
package trace_buffer_pkg;

    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_CYCLE_LIMIT = 2048;

    // Kind of value shown on the display / stored in an entry.
    typedef enum logic [1:0] {
        KIND_PC  = 2'd0,
        KIND_REG = 2'd1,
        KIND_MEM = 2'd2
    } kind_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // One trace entry: what was written and the written value.
    typedef struct packed {
        kind_e       kind;
        logic [31:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Circular buffer used to hold trace entries.
// Ports:
//   CLK_CPU     - clock, rising edge
//   RST_CPU     - asynchronous active-high reset (pointers, count, overflow)
//   push_i      - write push_data_i this edge
//   push_data_i - entry to store
//   pop_i       - discard the head entry this edge (ignored when empty)
//   count_o     - number of stored entries (0..DEPTH)
//   head_o      - oldest stored entry (combinational read at the read pointer)
//   overflow_o  - sticky: an entry was lost because a push hit a full buffer
// With OVERWRITE=1 a push into a full buffer (without a pop) replaces the
// oldest entry; with OVERWRITE=0 the new entry is discarded. Either way the
// overflow flag is set. A pop and a push on the same edge are handled as
// pop-then-push, so a full buffer with both keeps its count and no flag.
module trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 34,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic                     CLK_CPU,
    input  logic                     RST_CPU,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;

    logic full;
    logic do_pop;
    logic push_accept;   // push that fits (buffer not full, or made room by a pop)
    logic push_over;     // push into a full buffer that replaces the oldest entry
    logic push_drop;     // push that loses data (overwritten or discarded)
    logic wr_en;

    always_comb begin
        full        = (count_q == cnt_t'(DEPTH));
        do_pop      = pop_i && (count_q != '0);
        push_accept = push_i && (!full || do_pop);
        push_drop   = push_i && full && !do_pop;
        push_over   = push_drop && OVERWRITE;
        wr_en       = push_accept || push_over;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || push_drop;

        // Pointers are exactly PTR_W bits wide, so increments wrap modulo DEPTH.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        // Overwrite advances the read pointer past the replaced oldest entry.
        if (do_pop || push_over) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        if (push_accept && !do_pop) begin
            count_d = count_q + cnt_t'(1);
        end else if (do_pop && !push_accept) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is not reset; count/pointers define what is valid.
    always_ff @(posedge CLK_CPU) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o     = mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/trace_buffer.sv
// CPU execution trace buffer with single-step display readout.
// Captures GPR and data-memory writes while running, lets the user step
// through captured entries on a seg7 display, and halts after a fixed
// number of run cycles.
// Ports:
//   CLK_CPU, RST_CPU        - clock (rising edge), async active-high reset
//   pc_i                    - current PC, shown when the buffer is empty
//   reg_write_i/reg_wdata_i - GPR write strobe and data (captured first)
//   mem_write_i/mem_wdata_i - memory write strobe and data
//   freeze_i                - level, suspends capture and cycle counting
//   step_i                  - level, each rising edge pops one entry
//   disp_data_o/disp_kind_o - registered display value and its kind
//   count_o                 - entries held
//   overflow_o              - sticky, an entry was lost
//   cycle_cnt_o             - RUN cycles so far, saturating at CYCLE_LIMIT
//   halt_o                  - cycle limit reached
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
    input  logic                   CLK_CPU,
    input  logic                   RST_CPU,
    input  logic [31:0]            pc_i,
    input  logic                   reg_write_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic                   mem_write_i,
    input  logic [31:0]            mem_wdata_i,
    input  logic                   freeze_i,
    input  logic                   step_i,
    output logic [31:0]            disp_data_o,
    output logic [1:0]             disp_kind_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [31:0]            cycle_cnt_o,
    output logic                   halt_o
);

    localparam logic [31:0] LIMIT = 32'(CYCLE_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        step_prev_q;
    logic [31:0] disp_data_q, disp_data_d;
    kind_e       disp_kind_q, disp_kind_d;

    entry_t               push_entry;
    entry_t               head_entry;
    logic [ENTRY_W-1:0]   head_bits;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 push;
    logic                 pop;

    // Capture uses the current state only, so the edge that moves RUN to
    // FROZEN still records a write present on that edge.
    assign push = (state_q == ST_RUN) && (reg_write_i || mem_write_i);
    assign pop  = step_i && !step_prev_q;

    always_comb begin
        push_entry.kind = reg_write_i ? KIND_REG : KIND_MEM;
        push_entry.data = reg_write_i ? reg_wdata_i : mem_wdata_i;
    end

    trace_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (ENTRY_W),
        .OVERWRITE (1'b1)
    ) u_fifo (
        .CLK_CPU     (CLK_CPU),
        .RST_CPU     (RST_CPU),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (head_bits),
        .overflow_o  (overflow_o)
    );

    assign head_entry = entry_t'(head_bits);

    // State machine and run-cycle counter.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (cycle_cnt_q != LIMIT) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                // Reaching the limit wins over a simultaneous freeze request.
                if (cycle_cnt_d == LIMIT) begin
                    state_d = ST_HALTED;
                end else if (freeze_i) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (!freeze_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // The display samples the buffer as it stands before this edge, so a
    // new entry shows one cycle after it is captured (no bypass).
    always_comb begin
        disp_data_d = pc_i;
        disp_kind_d = KIND_PC;
        if (fifo_count != '0) begin
            disp_data_d = head_entry.data;
            disp_kind_d = head_entry.kind;
        end
    end

    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            state_q     <= ST_RUN;
            cycle_cnt_q <= '0;
            step_prev_q <= 1'b0;
            disp_data_q <= '0;
            disp_kind_q <= KIND_PC;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            step_prev_q <= step_i;
            disp_data_q <= disp_data_d;
            disp_kind_q <= disp_kind_d;
        end
    end

    assign disp_data_o = disp_data_q;
    assign disp_kind_o = disp_kind_q;
    assign count_o     = fifo_count;
    assign cycle_cnt_o = cycle_cnt_q;
    assign halt_o      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

    typedef logic [33:0] ent_t;   // {kind[1:0], data[31:0]}

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        reg_write_i;
    logic [31:0] reg_wdata_i;
    logic        mem_write_i;
    logic [31:0] mem_wdata_i;
    logic        freeze_i;
    logic        step_i;

    logic [31:0] disp_data,  disp_data8;
    logic [1:0]  disp_kind,  disp_kind8;
    logic [4:0]  count,      count8;
    logic        overflow,   overflow8;
    logic [31:0] cycle_cnt,  cycle_cnt8;
    logic        halt,       halt8;

    int checks = 0;
    int errors = 0;

    // Scoreboard model of the default-parameter instance.
    ent_t        mq[$];
    bit          m_run;
    logic        m_ovf;
    int unsigned m_cyc;
    logic        m_step_prev;
    ent_t        m_disp;

    trace_buffer dut (
        .CLK_CPU     (clk),
        .RST_CPU     (rst),
        .pc_i        (pc_i),
        .reg_write_i (reg_write_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_write_i (mem_write_i),
        .mem_wdata_i (mem_wdata_i),
        .freeze_i    (freeze_i),
        .step_i      (step_i),
        .disp_data_o (disp_data),
        .disp_kind_o (disp_kind),
        .count_o     (count),
        .overflow_o  (overflow),
        .cycle_cnt_o (cycle_cnt),
        .halt_o      (halt)
    );

    trace_buffer #(.CYCLE_LIMIT(8)) dut8 (
        .CLK_CPU     (clk),
        .RST_CPU     (rst),
        .pc_i        (pc_i),
        .reg_write_i (reg_write_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_write_i (mem_write_i),
        .mem_wdata_i (mem_wdata_i),
        .freeze_i    (freeze_i),
        .step_i      (step_i),
        .disp_data_o (disp_data8),
        .disp_kind_o (disp_kind8),
        .count_o     (count8),
        .overflow_o  (overflow8),
        .cycle_cnt_o (cycle_cnt8),
        .halt_o      (halt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Compare the default instance against the scoreboard.
    task automatic chk_model(input string tag);
        chk({tag, ".count"},    64'(count),     64'(mq.size()));
        chk({tag, ".overflow"}, 64'(overflow),  64'(m_ovf));
        chk({tag, ".cycles"},   64'(cycle_cnt), 64'(m_cyc));
        chk({tag, ".disp"},     {30'd0, disp_kind, disp_data}, 64'(m_disp));
    endtask

    // One clock cycle: inputs are already set (at a negedge); update the
    // model for the coming edge, then return at the following negedge.
    task automatic cyc();
        ent_t dn;
        bit   do_pop;
        bit   do_push;
        dn      = (mq.size() > 0) ? mq[0] : {2'd0, pc_i};
        do_pop  = step_i && !m_step_prev && (mq.size() > 0);
        do_push = m_run && (reg_write_i || mem_write_i);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() == 16) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
            mq.push_back(reg_write_i ? {2'd1, reg_wdata_i} : {2'd2, mem_wdata_i});
        end
        if (m_run) m_cyc++;
        m_run       = !freeze_i;
        m_step_prev = step_i;
        @(posedge clk);
        @(negedge clk);
        m_disp = dn;
        $display("cycle t=%0t count=%0d disp=%0d:0x%0h cyc=%0d", $time, count, disp_kind, disp_data, cycle_cnt);
    endtask

    task automatic model_reset();
        mq.delete();
        m_run       = 1'b1;
        m_ovf       = 1'b0;
        m_cyc       = 0;
        m_step_prev = 1'b0;
        m_disp      = '0;
    endtask

    // Asynchronous reset pulse, checked before any clock edge sees it.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reg_write_i = 1'b0;
        mem_write_i = 1'b0;
        step_i      = 1'b0;
        freeze_i    = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_model(tag);
        chk({tag, ".halt"}, 64'(halt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_i = 32'h0000_1000;
        reg_write_i = 1'b0; reg_wdata_i = '0;
        mem_write_i = 1'b0; mem_wdata_i = '0;
        freeze_i = 1'b0;    step_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_model("reset");
        chk("reset.halt", 64'(halt), 64'd0);
        rst = 1'b0;

        // Three REG captures; first one visible one cycle after its push.
        reg_write_i = 1'b1;
        reg_wdata_i = 32'h11; cyc();
        chk_model("push1");
        chk("push1.disp_is_pc", {30'd0, disp_kind, disp_data}, {30'd0, 2'd0, 32'h1000});
        reg_wdata_i = 32'h22; cyc();
        chk("push2.disp", {30'd0, disp_kind, disp_data}, {30'd0, 2'd1, 32'h11});
        reg_wdata_i = 32'h33; cyc();
        reg_write_i = 1'b0;
        chk("push3.count", 64'(count), 64'd3);
        chk_model("push3");

        // Step through the three entries.
        for (int i = 0; i < 3; i++) begin
            step_i = 1'b1; cyc();
            if (i == 2) pc_i = 32'h0000_ABCD;
            step_i = 1'b0; cyc();
            chk_model("step");
        end
        chk("step.pc_disp", {30'd0, disp_kind, disp_data}, {30'd0, 2'd0, 32'hABCD});
        chk("step.count0", 64'(count), 64'd0);

        // Step edge while empty is ignored.
        step_i = 1'b1; cyc();
        step_i = 1'b0; cyc();
        chk_model("empty_pop");

        // Simultaneous push and pop while empty keeps the new entry, no bypass.
        mem_write_i = 1'b1; mem_wdata_i = 32'h55; step_i = 1'b1; cyc();
        mem_write_i = 1'b0; step_i = 1'b0;
        chk("pp_empty.count", 64'(count), 64'd1);
        chk_model("pp_empty");
        cyc();
        chk("pp_empty.disp", {30'd0, disp_kind, disp_data}, {30'd0, 2'd2, 32'h55});

        // 17 MEM pushes into a 16-entry buffer: oldest overwritten.
        do_reset("rst2");
        mem_write_i = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            mem_wdata_i = 32'(i); cyc();
        end
        mem_write_i = 1'b0; cyc();
        chk("ovf.count", 64'(count), 64'd16);
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.head", {30'd0, disp_kind, disp_data}, {30'd0, 2'd2, 32'd2});
        chk_model("ovf");

        // Push and pop on the same edge when full (overflow already set).
        mem_write_i = 1'b1; mem_wdata_i = 32'h99; step_i = 1'b1; cyc();
        mem_write_i = 1'b0; step_i = 1'b0; cyc();
        chk_model("pp_full_ovf");

        // Same, starting from a full buffer with no overflow.
        do_reset("rst3");
        mem_write_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            mem_wdata_i = 32'(i + 100); cyc();
        end
        mem_wdata_i = 32'h77; step_i = 1'b1; cyc();
        mem_write_i = 1'b0; step_i = 1'b0; cyc();
        chk("pp_full.count", 64'(count), 64'd16);
        chk("pp_full.ovf", 64'(overflow), 64'd0);
        chk_model("pp_full");

        // Freeze for 10 cycles with writes active: only the entering edge captures.
        do_reset("rst4");
        freeze_i = 1'b1; reg_write_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            reg_wdata_i = 32'(i + 200); cyc();
        end
        chk("frz.count", 64'(count), 64'd1);
        chk("frz.cycles", 64'(cycle_cnt), 64'd1);
        chk_model("frz");
        freeze_i = 1'b0; reg_write_i = 1'b0;
        repeat (3) cyc();
        chk("unfrz.cycles", 64'(cycle_cnt), 64'd3);
        chk_model("unfrz");

        // Cycle limit of 8 on the second instance.
        do_reset("rst5");
        chk("lim.reset_cyc", 64'(cycle_cnt8), 64'd0);
        reg_write_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            reg_wdata_i = 32'(i); cyc();
            if (i == 7) begin
                chk("lim.e7.halt", 64'(halt8), 64'd0);
                chk("lim.e7.cyc", 64'(cycle_cnt8), 64'd7);
            end
            if (i == 8) begin
                chk("lim.e8.halt", 64'(halt8), 64'd1);
                chk("lim.e8.cyc", 64'(cycle_cnt8), 64'd8);
                chk("lim.e8.count", 64'(count8), 64'd8);
            end
        end
        chk("lim.end.halt", 64'(halt8), 64'd1);
        chk("lim.end.cyc", 64'(cycle_cnt8), 64'd8);
        chk("lim.end.count", 64'(count8), 64'd8);
        chk("lim.end.disp", {30'd0, disp_kind8, disp_data8}, {30'd0, 2'd1, 32'd1});
        chk_model("lim.main");

        // Mid-run reset pulse, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst.halt", 64'(halt8), 64'd0);
        chk("arst.cyc", 64'(cycle_cnt8), 64'd0);
        chk("arst.count", 64'(count8), 64'd0);
        chk("arst.disp", {30'd0, disp_kind8, disp_data8}, 64'd0);
        chk("arst.ovf_main", 64'(overflow), 64'd0);
        chk("arst.count_main", 64'(count), 64'd0);
        model_reset();
        reg_write_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        reg_write_i = 1'b1; reg_wdata_i = 32'hBEEF; cyc();
        reg_write_i = 1'b0;
        chk("post_rst.count8", 64'(count8), 64'd1);
        chk_model("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
